joystick_port: RTL and testbench
================================

JOYSTICK_PORT -- requirements
Module: joystick_port

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 50000, meaning the cycles a synchronized input must hold a new level before it is accepted (range 2..65535).
REQ-002 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port pins_n  input  8  raw active-low pins, asynchronous: [4:0]=joystick_0..4, [5]=button_select, [6]=button_0, [7]=button_halt.
REQ-005 SHALL have port address  input  2  register select.
REQ-006 SHALL have port bus_enable  input  1  one-cycle access strobe.
REQ-007 SHALL have port write_enable  input  1  qualifies bus_enable as a write.
REQ-008 SHALL have port data_in  input  8  write data.
REQ-009 SHALL have port data_out  output  8  read data, registered.
REQ-010 SHALL have port data_ready  output  1  one-cycle pulse marking data_out valid or write done.
REQ-011 SHALL have port irq  output  1  level interrupt, registered.

Function
REQ-012 SHALL pass each pins_n bit through a 2-flop synchronizer before use; no raw pin drives any other logic.
REQ-013 SHALL keep, per bit, a 16-bit debounce counter and a stable bit (1 = pressed = synchronized pin low).
REQ-014 SHALL, per bit, clear the counter on any cycle where the synchronized pressed level equals stable.
REQ-015 SHALL, per bit, increment the counter on each cycle where the levels differ, and on the cycle the counter equals DEBOUNCE_CYCLES-1 with a difference still present, update stable, clear the counter.
REQ-016 SHALL give pin-to-stable latency of exactly 2+DEBOUNCE_CYCLES clock edges for a clean level change; a differing level held fewer than DEBOUNCE_CYCLES cycles SHALL leave stable unchanged.
REQ-017 SHALL set press_flag[i] on the edge stable[i] goes 0->1 and release_flag[i] on the edge it goes 1->0; flags are sticky.
REQ-018 SHALL decode registers: 0 = stable (read-only), 1 = press_flag, 2 = release_flag, 3 = irq_mask (read/write).
REQ-019 SHALL on write to 1 or 2 clear each flag bit whose data_in bit is 1 (write-1-to-clear); write to 0 ignored; write to 3 loads irq_mask.
REQ-020 SHALL give set priority over clear when a flag sets and is cleared in the same cycle (flag ends 1).
REQ-021 SHALL on a read load data_out with the addressed register value as of that cycle and pulse data_ready the next edge (1-cycle latency); data_out holds until the next read.
REQ-022 SHALL pulse data_ready for one cycle after any write; data_out unchanged on writes.
REQ-023 SHALL ignore write_enable, address, data_in when bus_enable is 0; back-to-back strobes on consecutive cycles SHALL each complete.
REQ-024 SHALL drive irq = |(press_flag & irq_mask), registered, updating one edge after its inputs change.

Reset
REQ-025 SHALL on reset load synchronizer flops with 1 (released), clear all counters, stable, both flag registers, irq_mask, data_out, data_ready, irq to 0.
REQ-026 SHALL abort any in-progress debounce on reset; a pin held low through reset SHALL register as a press 2+DEBOUNCE_CYCLES edges after reset deasserts, setting press_flag.

Verification (DEBOUNCE_CYCLES=4)
REQ-027 SHALL verify: pins_n[0] 1->0 held -> stable[0]=1 and press_flag=0x01 after 6 edges, not after 5.
REQ-028 SHALL verify: pins_n[3] low for 3 cycles then high -> stable and flags remain 0x00.
REQ-029 SHALL verify: press bit 6, irq_mask=0x40 written -> irq=1; write 0x40 to address 1 -> press_flag=0x00, irq=0 one edge later.
REQ-030 SHALL verify: read address 0 with bits 0,5 pressed -> data_out=0x21, data_ready pulses one cycle, one edge after bus_enable.
REQ-031 SHALL verify: flag clear written same cycle bit 2 press edge occurs -> press_flag[2]=1.
REQ-032 SHALL verify: reset asserted mid-debounce (counter=2) -> all outputs 0x00/0, stable stays 0 for 6 edges after release.

Source files
------------

// File: rtl/joystick_port.sv
// ============================================================================
// Module   : joystick_port
// Brief    : Synchronised, debounced joystick/button port with sticky
//            press/release flags, write-1-to-clear, and masked interrupt.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module joystick_port #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] pins_n,
  input  logic [1:0] address,
  input  logic       bus_enable,
  input  logic       write_enable,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  output logic       data_ready,
  output logic       irq
);

  localparam logic [15:0] c_last_count = 16'(DEBOUNCE_CYCLES - 1);

  logic [7:0] r_sync1;
  logic [7:0] r_sync2;
  logic [7:0] r_stable;
  logic [7:0] r_press_flag;
  logic [7:0] r_release_flag;
  logic [7:0] r_irq_mask;
  logic [7:0] r_data_out;
  logic       r_data_ready;
  logic       r_irq;

  logic [7:0] w_pressed;
  logic [7:0] w_differ;
  logic [7:0] w_accept;
  logic [7:0] w_rise;
  logic [7:0] w_fall;
  logic       w_read;
  logic       w_write;
  logic [7:0] w_press_clr;
  logic [7:0] w_release_clr;
  logic [7:0] w_read_data;

  // Synchronisers reset to the released (high) level so a reset never
  // looks like a press on its own.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= 8'hFF;
      r_sync2 <= 8'hFF;
    end else begin
      r_sync1 <= pins_n;
      r_sync2 <= r_sync1;
    end
  end

  assign w_pressed = ~r_sync2;
  assign w_differ  = w_pressed ^ r_stable;

  genvar i;
  generate
    for (i = 0; i < 8; i++) begin : g_debounce
      logic [15:0] r_count;

      assign w_accept[i] = w_differ[i] && (r_count == c_last_count);

      always_ff @(posedge clk) begin
        if (reset || !w_differ[i] || w_accept[i]) begin
          r_count <= 16'd0;
        end else begin
          r_count <= r_count + 16'd1;
        end
      end
    end
  endgenerate

  // An accepted bit always differs from stable, so accepting is a toggle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stable <= 8'h00;
    end else begin
      r_stable <= r_stable ^ w_accept;
    end
  end

  assign w_rise = w_accept & w_pressed;
  assign w_fall = w_accept & ~w_pressed;

  assign w_read        = bus_enable && !write_enable;
  assign w_write       = bus_enable && write_enable;
  assign w_press_clr   = (w_write && address == 2'd1) ? data_in : 8'h00;
  assign w_release_clr = (w_write && address == 2'd2) ? data_in : 8'h00;

  always_comb begin
    w_read_data = 8'h00;
    case (address)
      2'd0:    w_read_data = r_stable;
      2'd1:    w_read_data = r_press_flag;
      2'd2:    w_read_data = r_release_flag;
      default: w_read_data = r_irq_mask;
    endcase
  end

  // Flag sets are OR-ed in after the clear so a simultaneous edge wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_press_flag   <= 8'h00;
      r_release_flag <= 8'h00;
      r_irq_mask     <= 8'h00;
      r_data_out     <= 8'h00;
      r_data_ready   <= 1'b0;
      r_irq          <= 1'b0;
    end else begin
      r_press_flag   <= (r_press_flag & ~w_press_clr) | w_rise;
      r_release_flag <= (r_release_flag & ~w_release_clr) | w_fall;
      if (w_write && address == 2'd3) begin
        r_irq_mask <= data_in;
      end
      if (w_read) begin
        r_data_out <= w_read_data;
      end
      r_data_ready <= bus_enable;
      r_irq        <= |(r_press_flag & r_irq_mask);
    end
  end

  assign data_out   = r_data_out;
  assign data_ready = r_data_ready;
  assign irq        = r_irq;

endmodule

`default_nettype wire

// File: tb/tb_joystick_port.sv
// ============================================================================
// Module   : tb_joystick_port
// Brief    : Directed self-checking bench for joystick_port (DEBOUNCE_CYCLES=4).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_joystick_port;

  logic       clk;
  logic       reset;
  logic [7:0] pins_n;
  logic [1:0] address;
  logic       bus_enable;
  logic       write_enable;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       data_ready;
  logic       irq;

  int n_checks;
  int n_pass;

  logic [7:0] r_data;
  logic       r_ready;

  joystick_port #(
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .pins_n       (pins_n),
    .address      (address),
    .bus_enable   (bus_enable),
    .write_enable (write_enable),
    .data_in      (data_in),
    .data_out     (data_out),
    .data_ready   (data_ready),
    .irq          (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%02h expected 0x%02h", tag, got, exp);
    end
  endtask

  // Inputs change on the falling edge; each bus task consumes one rising edge.
  task automatic bus_read(input logic [1:0] addr, output logic [7:0] data, output logic ready);
    bus_enable   = 1'b1;
    write_enable = 1'b0;
    address      = addr;
    @(negedge clk);
    bus_enable   = 1'b0;
    data         = data_out;
    ready        = data_ready;
  endtask

  task automatic bus_write(input logic [1:0] addr, input logic [7:0] wdata, output logic ready);
    bus_enable   = 1'b1;
    write_enable = 1'b1;
    address      = addr;
    data_in      = wdata;
    @(negedge clk);
    bus_enable   = 1'b0;
    write_enable = 1'b0;
    ready        = data_ready;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    n_checks     = 0;
    n_pass       = 0;
    reset        = 1'b1;
    pins_n       = 8'hFF;
    address      = 2'd0;
    bus_enable   = 1'b0;
    write_enable = 1'b0;
    data_in      = 8'h00;

    // Reset state
    idle(3);
    reset = 1'b0;
    check("rst_data_out", data_out, 8'h00);
    check("rst_data_ready", {7'd0, data_ready}, 8'h00);
    check("rst_irq", {7'd0, irq}, 8'h00);
    for (int a = 0; a < 4; a++) begin
      bus_read(2'(a), r_data, r_ready);
      check($sformatf("rst_reg%0d", a), r_data, 8'h00);
    end

    // Pin 0 press: stable after exactly 6 edges, not 5
    pins_n = 8'hFE;
    idle(5);
    bus_read(2'd0, r_data, r_ready);
    check("p0_stable_5", r_data, 8'h00);
    bus_read(2'd0, r_data, r_ready);
    check("p0_stable_6", r_data, 8'h01);
    bus_read(2'd1, r_data, r_ready);
    check("p0_press", r_data, 8'h01);
    pins_n = 8'hFF;
    idle(8);
    bus_read(2'd2, r_data, r_ready);
    check("p0_release", r_data, 8'h01);
    bus_write(2'd1, 8'hFF, r_ready);
    bus_write(2'd2, 8'hFF, r_ready);
    bus_read(2'd1, r_data, r_ready);
    check("p0_press_clr", r_data, 8'h00);
    bus_read(2'd2, r_data, r_ready);
    check("p0_release_clr", r_data, 8'h00);

    // Pin 3 glitch of 3 cycles is rejected
    pins_n = 8'hF7;
    idle(3);
    pins_n = 8'hFF;
    idle(8);
    bus_read(2'd0, r_data, r_ready);
    check("glitch_stable", r_data, 8'h00);
    bus_read(2'd1, r_data, r_ready);
    check("glitch_press", r_data, 8'h00);
    bus_read(2'd2, r_data, r_ready);
    check("glitch_release", r_data, 8'h00);

    // Bit 6 press, mask, irq, and W1C clear
    pins_n = 8'hBF;
    idle(8);
    bus_read(2'd0, r_data, r_ready);
    check("b6_stable", r_data, 8'h40);
    bus_write(2'd3, 8'h40, r_ready);
    check("wr_ready", {7'd0, r_ready}, 8'h01);
    check("wr_data_out_hold", data_out, 8'h40);
    check("irq_lag", {7'd0, irq}, 8'h00);
    idle(1);
    check("irq_set", {7'd0, irq}, 8'h01);
    bus_read(2'd3, r_data, r_ready);
    check("mask_rd", r_data, 8'h40);
    bus_write(2'd1, 8'h40, r_ready);
    check("irq_clr_lag", {7'd0, irq}, 8'h01);
    idle(1);
    check("irq_clr", {7'd0, irq}, 8'h00);
    bus_read(2'd1, r_data, r_ready);
    check("b6_press_clr", r_data, 8'h00);
    pins_n = 8'hFF;
    idle(8);
    bus_write(2'd2, 8'hFF, r_ready);

    // Read of bits 0 and 5 with one-cycle data_ready
    pins_n = 8'hDE;
    idle(8);
    check("rdy_idle", {7'd0, data_ready}, 8'h00);
    bus_read(2'd0, r_data, r_ready);
    check("rd21_data", r_data, 8'h21);
    check("rd21_ready", {7'd0, r_ready}, 8'h01);
    idle(1);
    check("rd21_ready_drop", {7'd0, data_ready}, 8'h00);
    check("rd21_data_hold", data_out, 8'h21);
    pins_n = 8'hFF;
    idle(8);
    bus_write(2'd1, 8'hFF, r_ready);
    bus_write(2'd2, 8'hFF, r_ready);

    // Bit 2 press edge coincides with a W1C write: set wins
    pins_n = 8'hFB;
    idle(5);
    bus_write(2'd1, 8'h04, r_ready);
    bus_read(2'd1, r_data, r_ready);
    check("set_wins", r_data, 8'h04);
    bus_write(2'd0, 8'hFF, r_ready);
    bus_read(2'd0, r_data, r_ready);
    check("wr0_ignored", r_data, 8'h04);
    bus_write(2'd3, 8'h04, r_ready);
    idle(1);
    check("irq_b2", {7'd0, irq}, 8'h01);

    // Reset mid-debounce of bit 1 (counter=2), pins held low through reset
    pins_n = 8'hF9;
    idle(4);
    reset = 1'b1;
    idle(1);
    check("mid_rst_data_out", data_out, 8'h00);
    check("mid_rst_ready", {7'd0, data_ready}, 8'h00);
    check("mid_rst_irq", {7'd0, irq}, 8'h00);
    idle(1);
    reset = 1'b0;
    idle(5);
    bus_read(2'd0, r_data, r_ready);
    check("post_rst_stable_5", r_data, 8'h00);
    bus_read(2'd0, r_data, r_ready);
    check("post_rst_stable_6", r_data, 8'h06);
    bus_read(2'd1, r_data, r_ready);
    check("post_rst_press", r_data, 8'h06);
    bus_read(2'd2, r_data, r_ready);
    check("post_rst_release", r_data, 8'h00);
    bus_read(2'd3, r_data, r_ready);
    check("post_rst_mask", r_data, 8'h00);
    check("post_rst_irq", {7'd0, irq}, 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
